// File: rtl/wb_cfg_pkg.sv
// Shared definitions for the Wishbone config streamer.
// Register offsets, STATUS bit positions and the shift engine state type.
package wb_cfg_pkg;

    localparam logic [4:0] OFF_STATUS   = 5'h00;
    localparam logic [4:0] OFF_DATA     = 5'h04;
    localparam logic [4:0] OFF_SET      = 5'h08;
    localparam logic [4:0] OFF_COUNT    = 5'h0C;
    localparam logic [4:0] OFF_READBACK = 5'h10;

    localparam int ST_SET_BUSY  = 0;
    localparam int ST_BUSY      = 1;
    localparam int ST_HOLD_FULL = 2;

    typedef enum logic {
        ENG_IDLE  = 1'b0,
        ENG_SHIFT = 1'b1
    } eng_state_e;

endpackage

// File: rtl/cfg_shift_engine.sv
// Double-buffered shift engine: holding reg, shift reg, word counter.
// Optional readback capture is built when CFG_READBACK_EN is defined.
module cfg_shift_engine
    import wb_cfg_pkg::*;
#(
    parameter int NUM_CHAINS = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic [31:0]           load_data,
    input  logic                  cnt_clr,
`ifdef CFG_READBACK_EN
    input  logic [NUM_CHAINS-1:0] shift_in,
`endif
    output logic                  hold_full,
    output logic                  busy,
    output logic                  cen,
    output logic [NUM_CHAINS-1:0] shift_out,
    output logic [CNT_W-1:0]      count,
    output logic [31:0]           readback
);

    localparam int STEPS  = 32 / NUM_CHAINS;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

    eng_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef CFG_READBACK_EN
    logic [31:0]       rb_sh_q, rb_sh_d;
    logic [31:0]       rb_q, rb_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ENG_IDLE;
            step_q      <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
`ifdef CFG_READBACK_EN
            rb_sh_q     <= '0;
            rb_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
`ifdef CFG_READBACK_EN
            rb_sh_q     <= rb_sh_d;
            rb_q        <= rb_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
`ifdef CFG_READBACK_EN
        rb_sh_d     = rb_sh_q;
        rb_d        = rb_q;
`endif
        if (state_q == ENG_SHIFT) begin
            shift_d = shift_q >> NUM_CHAINS;
            step_d  = step_q + 1'b1;
`ifdef CFG_READBACK_EN
            rb_sh_d = 32'({shift_in, rb_sh_q} >> NUM_CHAINS);
`endif
            if (step_q == LAST) begin
                cnt_d = cnt_q + 1'b1;
`ifdef CFG_READBACK_EN
                rb_d  = rb_sh_d;
`endif
                if (!hold_full_q)
                    state_d = ENG_IDLE;
            end
        end
        // Reload on the last step keeps cen high with no bubble.
        if (hold_full_q && (state_q == ENG_IDLE || step_q == LAST)) begin
            shift_d     = hold_q;
            step_d      = '0;
            hold_full_d = 1'b0;
            state_d     = ENG_SHIFT;
        end
        if (load_valid) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
        end
        if (cnt_clr)
            cnt_d = '0;
    end

    assign hold_full = hold_full_q;
    assign busy      = (state_q == ENG_SHIFT);
    assign cen       = (state_q == ENG_SHIFT);
    assign shift_out = shift_q[NUM_CHAINS-1:0];
    assign count     = cnt_q;
`ifdef CFG_READBACK_EN
    assign readback  = rb_q;
`else
    assign readback  = '0;
`endif

endmodule

// File: rtl/wishbone_config_streamer.sv
// Wishbone slave feeding parallel FPGA config chains with a timed set pulse.
// Define CFG_READBACK_EN to add the shift_in port and READBACK capture.
module wishbone_config_streamer
    import wb_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          NUM_CHAINS = 4,
    parameter int          SET_CYCLES = 2,
    parameter int          CNT_W      = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_data_i,
    input  logic [31:0]           wbs_addr_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_data_o,
    output logic                  cen,
    output logic [NUM_CHAINS-1:0] set_out,
    output logic [NUM_CHAINS-1:0] shift_out
`ifdef CFG_READBACK_EN
    ,
    input  logic [NUM_CHAINS-1:0] shift_in
`endif
);

    localparam int SC_W = $clog2(SET_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SET_CYCLES);

    logic                  ack_q, ack_d;
    logic [31:0]           data_q, data_d;
    logic [SC_W-1:0]       set_cnt_q, set_cnt_d;
    logic [NUM_CHAINS-1:0] set_mask_q, set_mask_d;

    logic [4:0]       off;
    logic             req, hit, full_word, accept;
    logic             is_status, is_data, is_set, is_count, is_rb;
    logic             load_valid, cnt_clr, set_busy;
    logic             hold_full, busy;
    logic [CNT_W-1:0] count;
    logic [31:0]      readback, status;

    cfg_shift_engine #(
        .NUM_CHAINS (NUM_CHAINS),
        .CNT_W      (CNT_W)
    ) u_engine (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_ni),
        .load_valid (load_valid),
        .load_data  (wbs_data_i),
        .cnt_clr    (cnt_clr),
`ifdef CFG_READBACK_EN
        .shift_in   (shift_in),
`endif
        .hold_full  (hold_full),
        .busy       (busy),
        .cen        (cen),
        .shift_out  (shift_out),
        .count      (count),
        .readback   (readback)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q      <= 1'b0;
            data_q     <= '0;
            set_cnt_q  <= '0;
            set_mask_q <= '0;
        end else begin
            ack_q      <= ack_d;
            data_q     <= data_d;
            set_cnt_q  <= set_cnt_d;
            set_mask_q <= set_mask_d;
        end
    end

    assign set_busy = (set_cnt_q != '0);

    always_comb begin
        off       = wbs_addr_i[4:0];
        hit       = (wbs_addr_i[31:5] == BASE_ADDR[31:5]);
        req       = wbs_stb_i & wbs_cyc_i & ~ack_q;
        full_word = (wbs_sel_i == 4'hF);
        is_status = (off == OFF_STATUS);
        is_data   = (off == OFF_DATA);
        is_set    = (off == OFF_SET);
        is_count  = (off == OFF_COUNT);
        is_rb     = (off == OFF_READBACK);

        status               = '0;
        status[ST_SET_BUSY]  = set_busy;
        status[ST_BUSY]      = busy;
        status[ST_HOLD_FULL] = hold_full;

        // A full DATA word against a full holding reg waits for the engine.
        accept = req & hit &
                 ~(wbs_we_i & is_data & full_word & hold_full);
        ack_d      = accept;
        load_valid = accept & wbs_we_i & is_data & full_word;
        cnt_clr    = accept & wbs_we_i & is_count;

        data_d = '0;
        if (accept && !wbs_we_i) begin
            unique case (1'b1)
                is_status: data_d = status;
                is_count:  data_d = 32'(count);
                is_rb:     data_d = readback;
                default:   data_d = '0;
            endcase
        end

        set_cnt_d  = set_cnt_q;
        set_mask_d = set_mask_q;
        if (set_busy) begin
            set_cnt_d = set_cnt_q - 1'b1;
        end else if (accept && wbs_we_i && is_set && !busy && !hold_full) begin
            set_cnt_d  = SC_LOAD;
            set_mask_d = wbs_data_i[NUM_CHAINS-1:0];
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_data_o = data_q;
    assign set_out    = set_busy ? set_mask_q : '0;

endmodule
